riscv_core_decode_unit: RTL and testbench
=========================================

# riscv_core_decode_unit

Registered, parametrised instruction-decode stage sitting between fetch and the register-read/execute stage of the RV64IMAC core. Decodes a 32-bit (already decompressed) instruction into the packed control word consumed by execute, and performs full illegal-instruction screening on opcode, funct3, funct5 and funct7 according to XLEN and the enabled extensions. Valid/ready handshakes on both sides, with a two-entry skid buffer so ready never depends combinationally on downstream ready. Also keeps a saturating count of illegal instructions issued.

## Interface
- XLEN, 64, datapath width; legal values 32 or 64.
- HAS_M, 1, M extension enabled.
- HAS_A, 1, A extension enabled.
- CNT_W, 16, illegal-counter width.
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  reset, asynchronous assert, active-low.
- i_decode_flush  in  1  kill all buffered entries.
- i_decode_valid  in  1  upstream instruction valid.
- o_decode_ready  out  1  upstream may transfer.
- i_decode_instr  in  32  instruction.
- i_decode_pc  in  XLEN  instruction PC.
- o_decode_valid  out  1  decoded entry valid.
- i_decode_ready  in  1  downstream accepts.
- o_decode_pc  out  XLEN  PC of the entry.
- o_decode_rd / o_decode_rs1 / o_decode_rs2  out  5 each  register indices.
- o_decode_ctrl  out  decode_ctrl_t  packed control word.
- o_decode_illegal  out  1  entry is an illegal instruction.
- o_decode_illegal_cnt  out  CNT_W  saturating illegal count.

## Operation
- Decode is combinational on i_decode_instr. The result, PC and indices are captured on an input transfer (i_decode_valid && o_decode_ready).
- decode_ctrl_t fields: regwrite, imsrc[2:0], uctrl, alusrcb, memwrite, resultsrc[1:0], branch, aluop, size[1:0], ldext, isword, jump, bjreg, imsel, new_mux_sel, amo, amo_op[3:0], lr, sc, csr_src_sel, csr_op[1:0], system. Legal-instruction encodings are unchanged from the current core.
- Illegal when any of the following holds:
  - Opcode is outside {OP, OP-32, OP-IMM, OP-IMM-32, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, AMO, SYSTEM}.
  - OP: funct7 is not 0000000. Exceptions: 0100000 is legal with funct3 000 or 101. 0000001 is legal only if HAS_M.
  - OP-32 / OP-IMM-32 when XLEN=32. OP-32 with funct3 in {001, 101} only accepts funct7 0000000 or 0100000 (0100000 only with funct3 101); M forms follow the OP rule.
  - LOAD with funct3 111. LOAD with funct3 011 or 110 when XLEN=32.
  - STORE with funct3[2]=1. STORE with funct3 011 when XLEN=32.
  - BRANCH with funct3 010 or 011.
  - JALR with funct3 not equal to 000.
  - AMO when !HAS_A. AMO with funct3 not in {010, 011} (011 is also illegal when XLEN=32). AMO with a funct5 outside the 11 defined encodings.
  - SYSTEM with funct3 100.
- SYSTEM with funct3 000 sets system=1 and is otherwise all zero.
- An illegal entry forces regwrite, memwrite, branch, jump, amo, lr and sc to 0. The other fields are don't-care and are driven to 0.
- Skid FSM has states EMPTY, ONE, TWO. Output comes from the main register; the skid register holds the second entry.
  - EMPTY: input transfer goes to ONE.
  - ONE: input and output transfer stays ONE, with main loaded from input. Input only goes to TWO. Output only goes to EMPTY.
  - TWO: output transfer goes to ONE, with skid moved into main.
- o_decode_ready = (state != TWO). It is registered-state-derived only.
- o_decode_valid = (state != EMPTY).
- The counter increments on an output transfer with o_decode_illegal=1 and saturates at all-ones. Flush does not clear it.

## Timing
- Reset values: o_decode_valid 0, o_decode_ready 1, all payload outputs 0, o_decode_illegal 0, counter 0.
- Latency: an input transfer at edge N makes the entry visible on the outputs after N, when the FSM is EMPTY, or when it is ONE with a simultaneous output transfer.
- Once asserted, o_decode_valid holds, and the payload stays stable, until i_decode_ready=1.
- Flush is synchronous and has priority. The FSM goes to EMPTY, and any same-cycle input transfer is discarded. An output transfer in the flush cycle still counts toward the counter.
- Asynchronous reset mid-operation drops all entries immediately. Outputs take their reset values while i_rst_n=0.
- Throughput is one instruction per cycle while downstream is ready.

## Structure
- Package riscv_core_pkg holds: decode_ctrl_t, the opcode localparams (OPC_OP, OPC_LOAD, …), AMO funct5 constants, and the skid state enum.
- Sub-module riscv_core_decode_logic is purely combinational: instr in, decode_ctrl_t and illegal out, with XLEN/HAS_M/HAS_A parameters. The top holds the FSM, registers and counter.

## Test plan
- Reset, then feed add x1,x2,x3 (0x003100B3) with downstream ready. One cycle later: o_decode_valid=1, rd=1, rs1=2, rs2=3, regwrite=1, illegal=0.
- Hold i_decode_ready=0 and push three instructions. Two are accepted, o_decode_ready drops after the second, the third stalls. Release downstream: outputs come out in order with no loss or duplication.
- With XLEN=32, send ld (funct3 011) and addw. Both give illegal=1, regwrite=0, and the counter ends at 2.
- With HAS_A=1, send amoadd.w: amo=1, amo_op=0001. With HAS_A=0, the same encoding gives illegal=1.
- In state TWO, assert flush together with i_decode_valid. Next cycle: o_decode_valid=0, o_decode_ready=1, and the flushed input never appears.
- Preset the counter near saturation (CNT_W=2) and issue 5 illegal instructions. The counter stops at 3.

Source files
------------

// File: rtl/riscv_core_decode_unit_pkg.sv
// Shared types and constants for the decode stage.
// Holds the packed control word, opcode/funct encodings and the skid state enum.
// Imported by the interface, the decode logic and the decode unit top.
package riscv_core_pkg;

  // Major opcodes of the base ISA plus A
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_AMO       = 7'b0101111;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // AMO funct5 encodings (the 11 defined ones)
  localparam logic [4:0] AMO_LR   = 5'b00010;
  localparam logic [4:0] AMO_SC   = 5'b00011;
  localparam logic [4:0] AMO_SWAP = 5'b00001;
  localparam logic [4:0] AMO_ADD  = 5'b00000;
  localparam logic [4:0] AMO_XOR  = 5'b00100;
  localparam logic [4:0] AMO_AND  = 5'b01100;
  localparam logic [4:0] AMO_OR   = 5'b01000;
  localparam logic [4:0] AMO_MIN  = 5'b10000;
  localparam logic [4:0] AMO_MAX  = 5'b10100;
  localparam logic [4:0] AMO_MINU = 5'b11000;
  localparam logic [4:0] AMO_MAXU = 5'b11100;

  // amo_op values seen by the memory-side AMO ALU
  localparam logic [3:0] AOP_SWAP = 4'b0000;
  localparam logic [3:0] AOP_ADD  = 4'b0001;
  localparam logic [3:0] AOP_XOR  = 4'b0010;
  localparam logic [3:0] AOP_AND  = 4'b0011;
  localparam logic [3:0] AOP_OR   = 4'b0100;
  localparam logic [3:0] AOP_MIN  = 4'b0101;
  localparam logic [3:0] AOP_MAX  = 4'b0110;
  localparam logic [3:0] AOP_MINU = 4'b0111;
  localparam logic [3:0] AOP_MAXU = 4'b1000;

  // Immediate format select
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  // Writeback result source
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;
  localparam logic [1:0] RES_CSR = 2'b11;

  typedef struct packed {
    logic       regwrite;
    logic [2:0] imsrc;
    logic       uctrl;
    logic       alusrcb;
    logic       memwrite;
    logic [1:0] resultsrc;
    logic       branch;
    logic       aluop;
    logic [1:0] size;
    logic       ldext;
    logic       isword;
    logic       jump;
    logic       bjreg;
    logic       imsel;
    logic       new_mux_sel;
    logic       amo;
    logic [3:0] amo_op;
    logic       lr;
    logic       sc;
    logic       csr_src_sel;
    logic [1:0] csr_op;
    logic       system;
  } decode_ctrl_t;

  typedef enum logic [1:0] {
    SKID_EMPTY = 2'd0,
    SKID_ONE   = 2'd1,
    SKID_TWO   = 2'd2
  } skid_state_e;

endpackage

// File: rtl/riscv_core_decode_unit_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// Master is the surrounding pipeline, slave is the decode unit.
// Carries valid/ready on both sides plus the decoded payload and illegal count.
interface riscv_core_decode_unit_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
);
  import riscv_core_pkg::*;

  logic              i_decode_flush;
  logic              i_decode_valid;
  logic              o_decode_ready;
  logic [31:0]       i_decode_instr;
  logic [XLEN-1:0]   i_decode_pc;
  logic              o_decode_valid;
  logic              i_decode_ready;
  logic [XLEN-1:0]   o_decode_pc;
  logic [4:0]        o_decode_rd;
  logic [4:0]        o_decode_rs1;
  logic [4:0]        o_decode_rs2;
  decode_ctrl_t      o_decode_ctrl;
  logic              o_decode_illegal;
  logic [CNT_W-1:0]  o_decode_illegal_cnt;

  modport master (
    output i_decode_flush, i_decode_valid, i_decode_instr, i_decode_pc, i_decode_ready,
    input  o_decode_ready, o_decode_valid, o_decode_pc, o_decode_rd, o_decode_rs1,
           o_decode_rs2, o_decode_ctrl, o_decode_illegal, o_decode_illegal_cnt
  );

  modport slave (
    input  i_decode_flush, i_decode_valid, i_decode_instr, i_decode_pc, i_decode_ready,
    output o_decode_ready, o_decode_valid, o_decode_pc, o_decode_rd, o_decode_rs1,
           o_decode_rs2, o_decode_ctrl, o_decode_illegal, o_decode_illegal_cnt
  );

endinterface

// File: rtl/riscv_core_decode_logic.sv
// Combinational RV64IMAC instruction decoder with illegal-instruction screening.
// Latency: zero cycles, pure combinational.
// Backpressure: none; the caller decides when the result is captured.
module riscv_core_decode_logic import riscv_core_pkg::*; #(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1,
  parameter bit HAS_A = 1'b1
) (
  input  logic [31:0]  instr,
  output decode_ctrl_t ctrl,
  output logic         illegal
);

  logic [6:0]   opcode;
  logic [2:0]   funct3;
  logic [6:0]   funct7;
  logic [4:0]   funct5;
  logic         rv32;
  logic         op_f7_ok;
  logic         bad;
  decode_ctrl_t raw;
  logic         unused_fields;

  assign opcode        = instr[6:0];
  assign funct3        = instr[14:12];
  assign funct7        = instr[31:25];
  assign funct5        = instr[31:27];
  assign rv32          = (XLEN == 32);
  assign unused_fields = ^{instr[24:15], instr[11:7]};

  // funct7 screen shared by OP and OP-32: base, SUB/SRA form, and M forms
  always_comb begin
    op_f7_ok = 1'b0;
    case (funct7)
      7'b0000000: op_f7_ok = 1'b1;
      7'b0100000: op_f7_ok = (funct3 == 3'b000) || (funct3 == 3'b101);
      7'b0000001: op_f7_ok = HAS_M;
      default:    op_f7_ok = 1'b0;
    endcase
  end

  // Per-opcode control word and illegal detection
  always_comb begin
    raw = '0;
    bad = 1'b0;
    case (opcode)
      OPC_OP, OPC_OP_32: begin
        raw.regwrite    = 1'b1;
        raw.aluop       = 1'b1;
        raw.isword      = (opcode == OPC_OP_32);
        raw.new_mux_sel = (funct7 == 7'b0000001);
        bad = !op_f7_ok || ((opcode == OPC_OP_32) && rv32);
      end
      OPC_OP_IMM, OPC_OP_IMM_32: begin
        raw.regwrite = 1'b1;
        raw.alusrcb  = 1'b1;
        raw.aluop    = 1'b1;
        raw.imsrc    = IMM_I;
        raw.isword   = (opcode == OPC_OP_IMM_32);
        bad = (opcode == OPC_OP_IMM_32) && rv32;
      end
      OPC_LOAD: begin
        raw.regwrite  = 1'b1;
        raw.alusrcb   = 1'b1;
        raw.imsrc     = IMM_I;
        raw.resultsrc = RES_MEM;
        raw.size      = funct3[1:0];
        raw.ldext     = funct3[2];
        bad = (funct3 == 3'b111) || (rv32 && ((funct3 == 3'b011) || (funct3 == 3'b110)));
      end
      OPC_STORE: begin
        raw.memwrite = 1'b1;
        raw.alusrcb  = 1'b1;
        raw.imsrc    = IMM_S;
        raw.size     = funct3[1:0];
        bad = funct3[2] || (rv32 && (funct3 == 3'b011));
      end
      OPC_BRANCH: begin
        raw.branch = 1'b1;
        raw.imsrc  = IMM_B;
        bad = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        raw.regwrite  = 1'b1;
        raw.jump      = 1'b1;
        raw.imsrc     = IMM_J;
        raw.resultsrc = RES_PC4;
      end
      OPC_JALR: begin
        raw.regwrite  = 1'b1;
        raw.jump      = 1'b1;
        raw.bjreg     = 1'b1;
        raw.alusrcb   = 1'b1;
        raw.imsrc     = IMM_I;
        raw.resultsrc = RES_PC4;
        bad = (funct3 != 3'b000);
      end
      OPC_LUI, OPC_AUIPC: begin
        raw.regwrite = 1'b1;
        raw.uctrl    = 1'b1;
        raw.alusrcb  = 1'b1;
        raw.imsrc    = IMM_U;
        raw.imsel    = (opcode == OPC_AUIPC);
      end
      OPC_AMO: begin
        raw.regwrite  = 1'b1;
        raw.resultsrc = RES_MEM;
        raw.size      = funct3[1:0];
        raw.isword    = (funct3 == 3'b010);
        bad = !HAS_A || !((funct3 == 3'b010) || (funct3 == 3'b011)) ||
              (rv32 && (funct3 == 3'b011));
        case (funct5)
          AMO_LR:   raw.lr = 1'b1;
          AMO_SC:   raw.sc = 1'b1;
          AMO_SWAP: begin raw.amo = 1'b1; raw.amo_op = AOP_SWAP; end
          AMO_ADD:  begin raw.amo = 1'b1; raw.amo_op = AOP_ADD;  end
          AMO_XOR:  begin raw.amo = 1'b1; raw.amo_op = AOP_XOR;  end
          AMO_AND:  begin raw.amo = 1'b1; raw.amo_op = AOP_AND;  end
          AMO_OR:   begin raw.amo = 1'b1; raw.amo_op = AOP_OR;   end
          AMO_MIN:  begin raw.amo = 1'b1; raw.amo_op = AOP_MIN;  end
          AMO_MAX:  begin raw.amo = 1'b1; raw.amo_op = AOP_MAX;  end
          AMO_MINU: begin raw.amo = 1'b1; raw.amo_op = AOP_MINU; end
          AMO_MAXU: begin raw.amo = 1'b1; raw.amo_op = AOP_MAXU; end
          default:  bad = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        if (funct3 == 3'b000) begin
          raw.system = 1'b1;
        end else if (funct3 == 3'b100) begin
          bad = 1'b1;
        end else begin
          raw.regwrite    = 1'b1;
          raw.resultsrc   = RES_CSR;
          raw.csr_src_sel = funct3[2];
          raw.csr_op      = funct3[1:0];
        end
      end
      default: bad = 1'b1;
    endcase
  end

  // Illegal entries carry an all-zero control word so nothing downstream acts on them
  assign ctrl    = bad ? '0 : raw;
  assign illegal = bad;

endmodule

// File: rtl/riscv_core_decode_unit.sv
// Registered decode stage: decodes fetch instructions into execute control words.
// Latency: one cycle from input transfer to output when the stage is draining.
// Backpressure: two-entry skid; ready comes only from registered state, never from downstream ready.
module riscv_core_decode_unit import riscv_core_pkg::*; #(
  parameter int XLEN  = 64,
  parameter bit HAS_M = 1'b1,
  parameter bit HAS_A = 1'b1,
  parameter int CNT_W = 16
) (
  input logic                     i_clk,
  input logic                     i_rst_n,
  riscv_core_decode_unit_if.slave dec_if
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    decode_ctrl_t    ctrl;
    logic            illegal;
  } entry_t;

  skid_state_e      state_q, state_nxt;
  entry_t           in_entry, main_q, skid_q;
  decode_ctrl_t     dec_ctrl;
  logic             dec_illegal;
  logic             in_xfer, out_xfer;
  logic             load_main_in, load_main_skid, load_skid;
  logic [CNT_W-1:0] cnt_q;

  riscv_core_decode_logic #(.XLEN(XLEN), .HAS_M(HAS_M), .HAS_A(HAS_A)) u_logic (
    .instr   (dec_if.i_decode_instr),
    .ctrl    (dec_ctrl),
    .illegal (dec_illegal)
  );

  assign in_entry = '{pc:      dec_if.i_decode_pc,
                      rd:      dec_if.i_decode_instr[11:7],
                      rs1:     dec_if.i_decode_instr[19:15],
                      rs2:     dec_if.i_decode_instr[24:20],
                      ctrl:    dec_ctrl,
                      illegal: dec_illegal};

  assign dec_if.o_decode_ready = (state_q != SKID_TWO);
  assign dec_if.o_decode_valid = (state_q != SKID_EMPTY);
  assign in_xfer  = dec_if.i_decode_valid && dec_if.o_decode_ready;
  assign out_xfer = dec_if.o_decode_valid && dec_if.i_decode_ready;

  // Skid state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= SKID_EMPTY;
    else          state_q <= state_nxt;
  end

  // Next state and register load enables; flush wins over everything
  always_comb begin
    state_nxt      = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      SKID_EMPTY: if (in_xfer) begin state_nxt = SKID_ONE; load_main_in = 1'b1; end
      SKID_ONE: begin
        if (in_xfer && out_xfer) load_main_in = 1'b1;
        else if (in_xfer)  begin state_nxt = SKID_TWO; load_skid = 1'b1; end
        else if (out_xfer) state_nxt = SKID_EMPTY;
      end
      SKID_TWO: if (out_xfer) begin state_nxt = SKID_ONE; load_main_skid = 1'b1; end
      default: state_nxt = SKID_EMPTY;
    endcase
    if (dec_if.i_decode_flush) begin
      state_nxt      = SKID_EMPTY;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  // Main (output) and skid payload registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_in)        main_q <= in_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= in_entry;
    end
  end

  // Saturating count of illegal entries handed to execute; flush leaves it alone
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cnt_q <= '0;
    else if (out_xfer && main_q.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  assign dec_if.o_decode_pc          = main_q.pc;
  assign dec_if.o_decode_rd          = main_q.rd;
  assign dec_if.o_decode_rs1         = main_q.rs1;
  assign dec_if.o_decode_rs2         = main_q.rs2;
  assign dec_if.o_decode_ctrl        = main_q.ctrl;
  assign dec_if.o_decode_illegal     = main_q.illegal;
  assign dec_if.o_decode_illegal_cnt = cnt_q;

endmodule

// File: tb/tb_riscv_core_decode_unit.sv
// Directed bench for the decode stage: an RV64 full-featured instance and an RV32, no-A,
// 2-bit-counter instance driven side by side from one linear stimulus sequence.
// Expected values are hand-computed from the instruction encodings.
module tb_riscv_core_decode_unit;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  riscv_core_decode_unit_if #(.XLEN(64), .CNT_W(16)) bus64 ();
  riscv_core_decode_unit_if #(.XLEN(32), .CNT_W(2))  bus32 ();

  riscv_core_decode_unit #(.XLEN(64), .HAS_M(1'b1), .HAS_A(1'b1), .CNT_W(16)) u_dut64 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .dec_if  (bus64)
  );

  riscv_core_decode_unit #(.XLEN(32), .HAS_M(1'b1), .HAS_A(1'b0), .CNT_W(2)) u_dut32 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .dec_if  (bus32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One-cycle input pulse on the RV64 instance; returns #1 after the capturing edge
  task automatic send64(input logic [31:0] ins, input logic [63:0] pc);
    bus64.i_decode_instr = ins;
    bus64.i_decode_pc    = pc;
    bus64.i_decode_valid = 1'b1;
    @(posedge clk); #1;
    bus64.i_decode_valid = 1'b0;
  endtask

  task automatic send32(input logic [31:0] ins, input logic [31:0] pc);
    bus32.i_decode_instr = ins;
    bus32.i_decode_pc    = pc;
    bus32.i_decode_valid = 1'b1;
    @(posedge clk); #1;
    bus32.i_decode_valid = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    bus64.i_decode_flush = 1'b0; bus64.i_decode_valid = 1'b0; bus64.i_decode_ready = 1'b0;
    bus64.i_decode_instr = '0;   bus64.i_decode_pc    = '0;
    bus32.i_decode_flush = 1'b0; bus32.i_decode_valid = 1'b0; bus32.i_decode_ready = 1'b0;
    bus32.i_decode_instr = '0;   bus32.i_decode_pc    = '0;

    // ---- reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", bus64.o_decode_valid, 0);
    chk("rst_ready", bus64.o_decode_ready, 1);
    chk("rst_pc",    bus64.o_decode_pc, 0);
    chk("rst_rd",    bus64.o_decode_rd, 0);
    chk("rst_ctrl",  bus64.o_decode_ctrl, 0);
    chk("rst_ill",   bus64.o_decode_illegal, 0);
    chk("rst_cnt",   bus64.o_decode_illegal_cnt, 0);
    rst_n = 1'b1;
    bus64.i_decode_ready = 1'b1;
    bus32.i_decode_ready = 1'b1;
    @(posedge clk); #1;

    // ---- add x1,x2,x3 visible one cycle after capture
    send64(32'h003100B3, 64'h1000);
    chk("add_valid", bus64.o_decode_valid, 1);
    chk("add_pc",    bus64.o_decode_pc, 64'h1000);
    chk("add_rd",    bus64.o_decode_rd, 1);
    chk("add_rs1",   bus64.o_decode_rs1, 2);
    chk("add_rs2",   bus64.o_decode_rs2, 3);
    chk("add_rw",    bus64.o_decode_ctrl.regwrite, 1);
    chk("add_ill",   bus64.o_decode_illegal, 0);

    // ---- back-to-back decodes on RV64 (downstream always ready)
    send64(32'h023100B3, 64'h1004);          // mul x1,x2,x3
    chk("mul_ill",  bus64.o_decode_illegal, 0);
    chk("mul_msel", bus64.o_decode_ctrl.new_mux_sel, 1);
    chk("mul_pc",   bus64.o_decode_pc, 64'h1004);
    send64(32'h403100B3, 64'h1008);          // sub x1,x2,x3
    chk("sub_ill",  bus64.o_decode_illegal, 0);
    chk("sub_rw",   bus64.o_decode_ctrl.regwrite, 1);
    send64(32'h403110B3, 64'h100C);          // funct7 0100000 with funct3 001
    chk("badf7_ill",  bus64.o_decode_illegal, 1);
    chk("badf7_ctrl", bus64.o_decode_ctrl, 0);
    send64(32'h00013083, 64'h1010);          // ld x1,0(x2)
    chk("ld64_ill", bus64.o_decode_illegal, 0);
    chk("ld64_res", bus64.o_decode_ctrl.resultsrc, 1);
    chk("ld64_sz",  bus64.o_decode_ctrl.size, 3);
    chk("ld64_cnt", bus64.o_decode_illegal_cnt, 1);
    send64(32'h003120AF, 64'h1014);          // amoadd.w x1,x3,(x2)
    chk("amo64_ill", bus64.o_decode_illegal, 0);
    chk("amo64_amo", bus64.o_decode_ctrl.amo, 1);
    chk("amo64_op",  bus64.o_decode_ctrl.amo_op, 4'b0001);
    send64(32'h00000073, 64'h1018);          // ecall
    chk("ecall_sys", bus64.o_decode_ctrl.system, 1);
    chk("ecall_rw",  bus64.o_decode_ctrl.regwrite, 0);
    @(posedge clk); #1;
    chk("drain_valid", bus64.o_decode_valid, 0);

    // ---- skid: three pushes with downstream stalled
    bus64.i_decode_ready = 1'b0;
    send64(32'h00100293, 64'h2000);          // addi x5,x0,1
    chk("sk_rdy1", bus64.o_decode_ready, 1);
    chk("sk_pc1",  bus64.o_decode_pc, 64'h2000);
    send64(32'h00200313, 64'h2004);          // addi x6,x0,2 -> skid
    chk("sk_rdy2", bus64.o_decode_ready, 0);
    chk("sk_pc2",  bus64.o_decode_pc, 64'h2000);
    bus64.i_decode_instr = 32'h00300393;     // addi x7,x0,3 stalls
    bus64.i_decode_pc    = 64'h2008;
    bus64.i_decode_valid = 1'b1;
    @(posedge clk); #1;
    chk("sk_hold_rdy", bus64.o_decode_ready, 0);
    chk("sk_hold_pc",  bus64.o_decode_pc, 64'h2000);
    chk("sk_hold_rd",  bus64.o_decode_rd, 5);
    bus64.i_decode_ready = 1'b1;
    @(posedge clk); #1;
    chk("sk_out2_pc",  bus64.o_decode_pc, 64'h2004);
    chk("sk_out2_rd",  bus64.o_decode_rd, 6);
    chk("sk_out2_rdy", bus64.o_decode_ready, 1);
    @(posedge clk); #1;
    bus64.i_decode_valid = 1'b0;
    chk("sk_out3_pc", bus64.o_decode_pc, 64'h2008);
    chk("sk_out3_rd", bus64.o_decode_rd, 7);
    @(posedge clk); #1;
    chk("sk_empty", bus64.o_decode_valid, 0);

    // ---- flush in TWO with input valid
    bus64.i_decode_ready = 1'b0;
    send64(32'h00100293, 64'h3000);
    send64(32'h00200313, 64'h3004);
    chk("fl_two", bus64.o_decode_ready, 0);
    bus64.i_decode_flush = 1'b1;
    bus64.i_decode_instr = 32'h00300393;
    bus64.i_decode_pc    = 64'h3008;
    bus64.i_decode_valid = 1'b1;
    @(posedge clk); #1;
    bus64.i_decode_flush = 1'b0;
    bus64.i_decode_valid = 1'b0;
    chk("fl_valid", bus64.o_decode_valid, 0);
    chk("fl_ready", bus64.o_decode_ready, 1);
    bus64.i_decode_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("fl_gone", bus64.o_decode_valid, 0);

    // ---- flush in ONE discards a same-cycle input transfer
    bus64.i_decode_ready = 1'b0;
    send64(32'h00100293, 64'h4000);
    bus64.i_decode_flush = 1'b1;
    bus64.i_decode_instr = 32'h00200313;
    bus64.i_decode_pc    = 64'h4004;
    bus64.i_decode_valid = 1'b1;
    @(posedge clk); #1;
    bus64.i_decode_flush = 1'b0;
    bus64.i_decode_valid = 1'b0;
    chk("fl1_valid", bus64.o_decode_valid, 0);
    @(posedge clk); #1;
    chk("fl1_gone", bus64.o_decode_valid, 0);

    // ---- output transfer in a flush cycle still counts an illegal entry
    send64(32'h00000000, 64'h5000);
    chk("flc_ill", bus64.o_decode_illegal, 1);
    bus64.i_decode_ready = 1'b1;
    bus64.i_decode_flush = 1'b1;
    @(posedge clk); #1;
    bus64.i_decode_flush = 1'b0;
    chk("flc_valid", bus64.o_decode_valid, 0);
    chk("flc_cnt",   bus64.o_decode_illegal_cnt, 2);

    // ---- RV32 / no-A instance: illegal screening and counter saturation
    send32(32'h00013083, 32'h100);           // ld: illegal on RV32
    chk("ld32_ill", bus32.o_decode_illegal, 1);
    chk("ld32_rw",  bus32.o_decode_ctrl.regwrite, 0);
    send32(32'h003100BB, 32'h104);           // addw: illegal on RV32
    chk("addw_ill", bus32.o_decode_illegal, 1);
    chk("addw_rw",  bus32.o_decode_ctrl.regwrite, 0);
    chk("addw_cnt", bus32.o_decode_illegal_cnt, 1);
    @(posedge clk); #1;
    chk("rv32_cnt2", bus32.o_decode_illegal_cnt, 2);
    send32(32'h003120AF, 32'h108);           // amoadd.w without A
    chk("amo32_ill", bus32.o_decode_illegal, 1);
    chk("amo32_amo", bus32.o_decode_ctrl.amo, 0);
    send32(32'h00000000, 32'h10C);
    chk("sat_cnt3", bus32.o_decode_illegal_cnt, 3);
    send32(32'h00013083, 32'h110);
    @(posedge clk); #1;
    chk("sat_cnt", bus32.o_decode_illegal_cnt, 3);
    chk("sat_valid", bus32.o_decode_valid, 0);

    // ---- asynchronous reset drops a held entry immediately
    bus64.i_decode_ready = 1'b0;
    send64(32'h00100293, 64'h6000);
    chk("ar_pre", bus64.o_decode_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", bus64.o_decode_valid, 0);
    chk("ar_ready", bus64.o_decode_ready, 1);
    chk("ar_pc",    bus64.o_decode_pc, 0);
    chk("ar_cnt",   bus64.o_decode_illegal_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
